// File: rtl/sd_pulse_sched.sv
// rtl/sd_pulse_sched.sv - round-robin event scheduler sharing one pulse-synchronizer channel
// Optional sticky overflow flags: define SD_PULSE_SCHED_OVF_EN.
module sd_pulse_sched #(
  parameter int nsrc      = 4,
  parameter int cnt_width = 4,
  parameter int id_width  = 2,
  parameter int min_gap   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [nsrc-1:0]     req_pulse,
  output logic                sync_pulse,
  output logic [id_width-1:0] sync_id,
  output logic                busy,
  output logic                pending_any,
  output logic [nsrc-1:0]     ovf,
  input  logic [nsrc-1:0]     ovf_clr
);

  localparam int gap_w = (min_gap > 2) ? $clog2(min_gap) : 1;
  localparam logic [cnt_width-1:0] cnt_max = {cnt_width{1'b1}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [gap_w-1:0]     gap_q, gap_d;
  logic                 sync_pulse_q, sync_pulse_d;
  logic [id_width-1:0]  sync_id_q, sync_id_d;
  logic                 busy_q, busy_d;
  logic [id_width-1:0]  last_q, last_d;
  logic [nsrc-1:0]      ovf_q, ovf_d;
  logic [cnt_width-1:0] pending_q [nsrc];
  logic [cnt_width-1:0] pending_d [nsrc];

  logic                 grant;
  logic                 found;
  logic [id_width-1:0]  win;
  logic [nsrc-1:0]      drop;

  // Any source with a nonzero count is waiting for the channel.
  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < nsrc; i++) begin
      if (pending_q[i] != '0) pending_any = 1'b1;
    end
  end

  // Round-robin pick: first pending source after the last winner.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int k = 1; k <= nsrc; k++) begin
      idx = (int'(last_q) + k) % nsrc;
      if (!found && pending_q[idx] != '0) begin
        found = 1'b1;
        win   = id_width'(idx);
      end
    end
  end

  assign grant = (state_q == IDLE) && pending_any;

  // Per-source counters; a same-cycle event and grant cancel out.
  always_comb begin
    for (int i = 0; i < nsrc; i++) begin
      logic inc;
      logic dec;
      inc          = req_pulse[i];
      dec          = grant && (win == id_width'(i));
      pending_d[i] = pending_q[i];
      drop[i]      = 1'b0;
      if (inc && !dec) begin
        if (pending_q[i] == cnt_max) drop[i] = 1'b1;
        else pending_d[i] = pending_q[i] + cnt_width'(1);
      end else if (!inc && dec) begin
        pending_d[i] = pending_q[i] - cnt_width'(1);
      end
    end
  end

`ifdef SD_PULSE_SCHED_OVF_EN
  // Sticky overflow: a dropped increment sets, clear only wins when no new drop.
  always_comb begin
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, drop, ovf_q};

  // Overflow reporting compiled out; flag stays low.
  always_comb begin
    ovf_d = '0;
  end
`endif

  // Channel FSM: grant in IDLE, one-cycle pulse in ISSUE, spacing in GAP.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    sync_pulse_d = 1'b0;
    sync_id_d    = sync_id_q;
    last_d       = last_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = ISSUE;
          sync_pulse_d = 1'b1;
          sync_id_d    = win;
          last_d       = win;
        end
      end
      ISSUE: begin
        gap_d   = gap_w'(min_gap - 2);
        // With the minimum gap the IDLE cycle alone provides the spacing.
        state_d = (min_gap > 2) ? GAP : IDLE;
      end
      GAP: begin
        gap_d = gap_q - gap_w'(1);
        if (gap_q == gap_w'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers with synchronous reset; reset also drops any in-flight pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      sync_pulse_q <= 1'b0;
      sync_id_q    <= '0;
      busy_q       <= 1'b0;
      last_q       <= id_width'(nsrc - 1);
      ovf_q        <= '0;
      for (int i = 0; i < nsrc; i++) pending_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      sync_pulse_q <= sync_pulse_d;
      sync_id_q    <= sync_id_d;
      busy_q       <= busy_d;
      last_q       <= last_d;
      ovf_q        <= ovf_d;
      for (int i = 0; i < nsrc; i++) pending_q[i] <= pending_d[i];
    end
  end

  assign sync_pulse = sync_pulse_q;
  assign sync_id    = sync_id_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;

endmodule
